// File: rtl/spi_master_ctrl_if.sv
// rtl/spi_master_ctrl_if.sv - host register-block control/status bundle for spi_master_ctrl
interface spi_master_ctrl_if;
  logic [4:0]  spi_rw_len;
  logic        spi_ch_sel;
  logic        spi_d_rise_align;
  logic [31:0] spi_wdata;
  logic        spi_wr_en;
  logic        spi_rd_en;
  logic [31:0] spi_rdata;
  logic        spi_busy;

  modport master (
    output spi_rw_len, spi_ch_sel, spi_d_rise_align, spi_wdata, spi_wr_en, spi_rd_en,
    input  spi_rdata, spi_busy
  );

  modport slave (
    input  spi_rw_len, spi_ch_sel, spi_d_rise_align, spi_wdata, spi_wr_en, spi_rd_en,
    output spi_rdata, spi_busy
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - single-transfer SPI master engine, 1..32 bits, two chip selects
// Optional SPI_3WIRE_EN adds sdio_oe_o and instruction-phase handling for a bidirectional SDIO pad.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rstb,
  spi_master_ctrl_if.slave host,
  output logic             sclk_o,
  output logic [1:0]       csb_o,
  output logic             mosi_o,
  input  logic             miso_i
`ifdef SPI_3WIRE_EN
  ,
  output logic             sdio_oe_o
`endif
);

  localparam int             CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    hp_q, hp_d;
  logic [4:0]    len_q, len_d;
  logic          align_q, align_d;
  logic          rd_q, rd_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic          sclk_q, sclk_d;
  logic [1:0]    csb_q, csb_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic [31:0]   rdata_q, rdata_d;
`ifdef SPI_3WIRE_EN
  logic          oe_q, oe_d;
  logic [5:0]    txn_q, txn_d;
  logic [5:0]    rxn_q, rxn_d;
`endif

  logic          tick;
  logic          last_hp;
  logic          rise_ev;
  logic          fall_ev;
  logic          launch;
  logic          capture;
  logic [31:0]   tx_init;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hp_q    <= '0;
      len_q   <= '0;
      align_q <= 1'b0;
      rd_q    <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      csb_q   <= 2'b11;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
`ifdef SPI_3WIRE_EN
      oe_q    <= 1'b0;
      txn_q   <= '0;
      rxn_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hp_q    <= hp_d;
      len_q   <= len_d;
      align_q <= align_d;
      rd_q    <= rd_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      csb_q   <= csb_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
`ifdef SPI_3WIRE_EN
      oe_q    <= oe_d;
      txn_q   <= txn_d;
      rxn_q   <= rxn_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hp_d    = hp_q;
    len_d   = len_q;
    align_d = align_q;
    rd_d    = rd_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    csb_d   = csb_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    rdata_d = rdata_q;
`ifdef SPI_3WIRE_EN
    oe_d    = oe_q;
    txn_d   = txn_q;
    rxn_d   = rxn_q;
`endif
    tick    = (cnt_q == CNT_LAST);
    last_hp = (hp_q == {len_q, 1'b1});
    rise_ev = 1'b0;
    fall_ev = 1'b0;
    launch  = 1'b0;
    capture = 1'b0;
    // Word pre-shifted so bit N-1 sits at bit 31 and leaves MSB first.
    tx_init = host.spi_wdata << (5'd31 - host.spi_rw_len);

    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (host.spi_wr_en || host.spi_rd_en) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          hp_d    = '0;
          len_d   = host.spi_rw_len;
          align_d = host.spi_d_rise_align;
          rd_d    = host.spi_rd_en;
          rx_d    = '0;
          busy_d  = 1'b1;
          csb_d   = host.spi_ch_sel ? 2'b01 : 2'b10;
          tx_d    = tx_init;
`ifdef SPI_3WIRE_EN
          oe_d    = 1'b1;
          txn_d   = '0;
          rxn_d   = '0;
`endif
          if (!host.spi_d_rise_align) begin
            mosi_d = tx_init[31];
            tx_d   = {tx_init[30:0], 1'b0};
`ifdef SPI_3WIRE_EN
            txn_d  = 6'd1;
`endif
          end
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_SHIFT;
          sclk_d  = 1'b1;
          rise_ev = 1'b1;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          if (last_hp) begin
            state_d = S_HOLD;
          end else begin
            hp_d    = hp_q + 6'd1;
            sclk_d  = ~sclk_q;
            rise_ev = hp_q[0];
            fall_ev = ~hp_q[0];
          end
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d = S_GAP;
          csb_d   = 2'b11;
          mosi_d  = 1'b0;
          if (rd_q) begin
            rdata_d = rx_q;
          end
`ifdef SPI_3WIRE_EN
          oe_d    = 1'b0;
`endif
        end
      end
      S_GAP: begin
        if (tick) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Align=0 never launches on the final falling edge; there is no bit left to send.
    launch  = align_q ? rise_ev : (fall_ev && (hp_q != {len_q, 1'b0}));
    capture = align_q ? fall_ev : rise_ev;

    if (launch) begin
      mosi_d = tx_q[31];
      tx_d   = {tx_q[30:0], 1'b0};
`ifdef SPI_3WIRE_EN
      txn_d  = txn_q + 6'd1;
      if (rd_q && (txn_q == 6'd16)) begin
        oe_d = 1'b0;
      end
`endif
    end

    if (capture) begin
`ifdef SPI_3WIRE_EN
      rxn_d = rxn_q + 6'd1;
      if (rxn_q >= 6'd16) begin
        rx_d = {rx_q[30:0], miso_i};
      end
`else
      rx_d = {rx_q[30:0], miso_i};
`endif
    end
  end

  assign sclk_o         = sclk_q;
  assign csb_o          = csb_q;
  assign mosi_o         = mosi_q;
  assign host.spi_rdata = rdata_q;
  assign host.spi_busy  = busy_q;
`ifdef SPI_3WIRE_EN
  assign sdio_oe_o      = oe_q;
`endif

endmodule
